master_port: RTL



---
 rtl/bus_pkg.sv | 26 ++
 rtl/master_port_if.sv | 30 +++
 rtl/master_port_counter.sv | 36 +++
 rtl/master_port.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and sizing for the serial bus master port.
package bus_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int DATA_IDX_W  = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        ADDR,
        WAIT_AACK,
        AACK_END,
        WDATA,
        WAIT_DACK,
        RDATA,
        FINISH
    } state_t;

endpackage

// File: rtl/master_port_if.sv
// User-side request/response signals and serial bus signals of the master port.
interface master_port_if;
    import bus_pkg::*;

    logic              M_REQ;
    logic              M_RW;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic              M_READY;
    logic              M_DONE;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_ERR;
    logic              B_UTIL;
    logic              B_RW;
    logic              B_BUS_OUT;
    logic              B_ACK;
    logic              B_SBSY;
    logic              B_BUS_IN;

    modport master (
        input  M_REQ, M_RW, M_ADDR, M_WDATA, B_ACK, B_SBSY, B_BUS_IN,
        output M_READY, M_DONE, M_RDATA, M_ERR, B_UTIL, B_RW, B_BUS_OUT
    );

    modport slave (
        output M_REQ, M_RW, M_ADDR, M_WDATA, B_ACK, B_SBSY, B_BUS_IN,
        input  M_READY, M_DONE, M_RDATA, M_ERR, B_UTIL, B_RW, B_BUS_OUT
    );

endinterface

// File: rtl/master_port_counter.sv
// Shared bit/timeout counter: synchronous clear (rst) has priority over incr.
module master_port_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst,
    input  logic             incr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/master_port.sv
// Serial bus master: shifts address/write data out LSB first, handles ack
// handshakes with timeout, and shifts read data in. All outputs are registered.
module master_port
    import bus_pkg::*;
(
    input  logic          CLK,
    input  logic          RSTN,
    master_port_if.master bus
);

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              dack_seen_q, dack_seen_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              m_ready_q, m_ready_d;
    logic              m_done_q, m_done_d;
    logic              m_err_q, m_err_d;
    logic              b_util_q, b_util_d;
    logic              b_rw_q, b_rw_d;
    logic              b_bus_out_q, b_bus_out_d;

    logic              cnt_rst;
    logic              cnt_incr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    master_port_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk        (CLK),
        .rst_n      (RSTN),
        .rst        (cnt_rst),
        .incr       (cnt_incr),
        .count      (cnt),
        .count_next (cnt_next)
    );

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        dack_seen_d = dack_seen_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        cnt_rst     = 1'b0;
        cnt_incr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_ready_q && bus.M_REQ && !bus.B_SBSY) begin
                    rw_d    = bus.M_RW;
                    addr_d  = bus.M_ADDR;
                    wdata_d = bus.M_WDATA;
                    err_d   = 1'b0;
                    cnt_rst = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_rst = 1'b1;
                state_d = ADDR;
            end
            ADDR: begin
                if (cnt == ADDR_LAST) begin
                    cnt_rst = 1'b1;
                    state_d = WAIT_AACK;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            WAIT_AACK: begin
                if (bus.B_ACK) begin
                    cnt_rst = 1'b1;
                    state_d = AACK_END;
                end else if (cnt == ACK_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            AACK_END: begin
                if (!bus.B_ACK) begin
                    cnt_rst = 1'b1;
                    state_d = rw_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (cnt == DATA_LAST) begin
                    cnt_rst     = 1'b1;
                    dack_seen_d = 1'b0;
                    state_d     = WAIT_DACK;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            // Timeout only guards the rising ack; once seen, wait for it to drop.
            WAIT_DACK: begin
                if (dack_seen_q) begin
                    if (!bus.B_ACK) begin
                        state_d = FINISH;
                    end
                end else if (bus.B_ACK) begin
                    dack_seen_d = 1'b1;
                end else if (cnt == ACK_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            RDATA: begin
                shift_d[cnt[DATA_IDX_W-1:0]] = bus.B_BUS_IN;
                if (cnt == DATA_LAST) begin
                    rdata_d = shift_d;
                    state_d = FINISH;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            FINISH: begin
                err_d       = 1'b0;
                dack_seen_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        m_ready_d   = (state_d == IDLE);
        m_done_d    = (state_d == FINISH);
        m_err_d     = (state_d == FINISH) && err_d;
        b_util_d    = !(state_d inside {IDLE, FINISH});
        b_rw_d      = b_util_d && rw_d;
        b_bus_out_d = 1'b0;
        case (state_d)
            ADDR:    b_bus_out_d = addr_d[cnt_next];
            WDATA:   b_bus_out_d = wdata_d[cnt_next[DATA_IDX_W-1:0]];
            default: b_bus_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            dack_seen_q <= 1'b0;
            shift_q     <= '0;
            rdata_q     <= '0;
            m_ready_q   <= 1'b0;
            m_done_q    <= 1'b0;
            m_err_q     <= 1'b0;
            b_util_q    <= 1'b0;
            b_rw_q      <= 1'b0;
            b_bus_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            dack_seen_q <= dack_seen_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            m_ready_q   <= m_ready_d;
            m_done_q    <= m_done_d;
            m_err_q     <= m_err_d;
            b_util_q    <= b_util_d;
            b_rw_q      <= b_rw_d;
            b_bus_out_q <= b_bus_out_d;
        end
    end

    assign bus.M_READY   = m_ready_q;
    assign bus.M_DONE    = m_done_q;
    assign bus.M_ERR     = m_err_q;
    assign bus.M_RDATA   = rdata_q;
    assign bus.B_UTIL    = b_util_q;
    assign bus.B_RW      = b_rw_q;
    assign bus.B_BUS_OUT = b_bus_out_q;

endmodule
